// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B subtractor with start/busy/done handshake and serial difference stream
//
// Purpose:
//   Computes diff = a - b (mod 2^WIDTH) one bit per clock, LSB first, using a
//   single full-subtractor cell and a registered borrow. Operands are captured
//   on the accepting edge; the result, the final borrow and the two's-complement
//   overflow flag are published when the operation completes and held until
//   the next completion or reset.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - operation request, honoured in IDLE or DONE
//   a, b       - minuend / subtrahend, captured on the accepting edge only
//   diff       - a - b mod 2^WIDTH, valid while done=1 and held afterwards
//   borrow_out - final borrow, 1 iff unsigned a < b
//   overflow   - two's-complement overflow of a - b
//   busy       - high while the serial steps are running
//   done       - one-cycle completion pulse
//   diff_bit   - difference bit produced by the current step, LSB first
//   diff_valid - qualifies diff_bit, high for exactly WIDTH cycles per operation

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             diff_bit,
    output logic             diff_valid
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             msb_a;
    logic             msb_b;

    logic             step_d;
    logic             step_borrow;
    logic             last_step;
    logic             accept;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell working on the current LSBs of the shift registers.
    always_comb begin
        step_d      = a_sh[0] ^ b_sh[0] ^ borrow;
        step_borrow = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        last_step   = (count == CW'(WIDTH - 1));
        accept      = start && ((state == IDLE) || (state == DONE));
        // Shifting in from the MSB side leaves the bits in natural order
        // once all WIDTH steps have been taken.
        res_next    = {step_d, res_sh[WIDTH-1:1]};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        diff_valid = 1'b0;
        diff_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                diff_valid = 1'b1;
                diff_bit   = step_d;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // Back-to-back issue skips IDLE entirely.
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            msb_a      <= 1'b0;
            msb_b      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
            msb_a  <= a[WIDTH-1];
            msb_b  <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh <= res_next;
            borrow <= step_borrow;
            count  <= count + CW'(1);
            if (last_step) begin
                // Publish on the final step so the flags are valid throughout DONE.
                // step_d here is the MSB of the result.
                diff       <= res_next;
                borrow_out <= step_borrow;
                overflow   <= (msb_a != msb_b) && (step_d != msb_a);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor against an arithmetic reference model

module tb_serial_subtractor;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         busy;
    logic         done;
    logic         diff_bit;
    logic         diff_valid;

    int n_checks;
    int n_fail;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done),
        .diff_bit   (diff_bit),
        .diff_valid (diff_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic int model_diff(input int ta, input int tb);
        return (ta - tb) & MASK;
    endfunction

    function automatic int model_borrow(input int ta, input int tb);
        return (ta < tb) ? 1 : 0;
    endfunction

    function automatic int model_ovf(input int ta, input int tb);
        int sa, sb, sd;
        sa = (ta >= (1 << (W - 1))) ? ta - (1 << W) : ta;
        sb = (tb >= (1 << (W - 1))) ? tb - (1 << W) : tb;
        sd = sa - sb;
        return (sd > (1 << (W - 1)) - 1 || sd < -(1 << (W - 1))) ? 1 : 0;
    endfunction

    // Present a request; called just after a rising edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb);
        a     = ta;
        b     = tb;
        start = 1'b1;
    endtask

    // Follows one operation from its accepting edge to completion.
    // glitch : pulse start with other operands in the second RUN cycle
    // scramble: randomise a/b every cycle after acceptance
    // chain  : raise start with na/nb during DONE for a back-to-back issue
    task automatic exec(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input bit glitch, input bit scramble,
                        input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
        int exp_d, exp_b, exp_o, valid_cnt;
        exp_d = model_diff(int'(ta), int'(tb));
        exp_b = model_borrow(int'(ta), int'(tb));
        exp_o = model_ovf(int'(ta), int'(tb));
        valid_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin a = W'($urandom); b = W'($urandom); end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("diff_bit", diff_bit, (exp_d >> i) & 1);
            if (diff_valid) valid_cnt++;
            if (glitch && i == 1) begin
                a = '1; b = '0; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (scramble) begin a = W'($urandom); b = W'($urandom); end
        end
        @(negedge clk);
        check("valid_cycles", valid_cnt, W);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_valid", diff_valid, 0);
        check("diff", diff, exp_d);
        check("borrow_out", borrow_out, exp_b);
        check("overflow", overflow, exp_o);
        if (chain) begin
            issue(na, nb);
        end else begin
            @(posedge clk); #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("hold_diff", diff, exp_d);
            check("hold_borrow", borrow_out, exp_b);
            check("hold_ovf", overflow, exp_o);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {diff, borrow_out, overflow, busy, done, diff_bit, diff_valid}, 0);
    endtask

    initial begin
        logic [W-1:0] ca, cb, nxa, nxb;
        bit ch, sc;
        int done_seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(4'b1101, 4'b1011); exec(4'b1101, 4'b1011, 0, 0, 0, 0, 0);
        issue(4'b1011, 4'b1101); exec(4'b1011, 4'b1101, 0, 0, 0, 0, 0);
        issue(4'b0111, 4'b1000); exec(4'b0111, 4'b1000, 0, 0, 0, 0, 0);
        issue(4'b1000, 4'b0001); exec(4'b1000, 4'b0001, 0, 0, 0, 0, 0);
        // Ignored start in RUN, then back-to-back issue from DONE
        issue(4'b0101, 4'b0011); exec(4'b0101, 4'b0011, 1, 0, 1, 4'b0000, 4'b0001);
        exec(4'b0000, 4'b0001, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-RUN aborts with no done pulse
        issue(4'b1001, 4'b0110);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        done_seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'b0110, 4'b0110); exec(4'b0110, 4'b0110, 0, 0, 0, 0, 0);

        // Operands changing every cycle after capture
        issue(4'b1010, 4'b0101); exec(4'b1010, 4'b0101, 0, 1, 0, 0, 0);

        // Random operations, some chained back-to-back
        ca = W'($urandom);
        cb = W'($urandom);
        issue(ca, cb);
        for (int k = 0; k < 30; k++) begin
            ch  = (k < 29) ? bit'($urandom_range(0, 1)) : 1'b0;
            sc  = bit'($urandom_range(0, 1));
            nxa = W'($urandom);
            nxb = W'($urandom);
            exec(ca, cb, 0, sc, ch, nxa, nxb);
            ca = nxa;
            cb = nxb;
            if (!ch) issue(ca, cb);
        end
        start = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
